// File: rtl/alu_pkg.sv
// Shared constants for the ALU-sharing arbiter: datapath widths and the
// 3-bit ALU control encoding understood by the shared ALU.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 3;

    localparam logic [CTRL_W-1:0] ALU_AND = 3'd0;
    localparam logic [CTRL_W-1:0] ALU_OR  = 3'd1;
    localparam logic [CTRL_W-1:0] ALU_ADD = 3'd2;
    localparam logic [CTRL_W-1:0] ALU_SUB = 3'd6;
    localparam logic [CTRL_W-1:0] ALU_SLT = 3'd7;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// rr_ptr (wrapping), producing a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (en && !any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU among NUM_REQ requesters with an
// operand stage and a result stage. Define ALU_ARB_STATS_EN for per-requester grant counters.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [CTRL_W-1:0]         alu_ctrl,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_zero,
    output logic [ID_W-1:0]           rsp_id
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

    logic              op_valid;
    logic [DATA_W-1:0] op_a, op_b;
    logic [CTRL_W-1:0] op_ctrl;
    logic [ID_W-1:0]   op_id;
    logic [ID_W-1:0]   rr_ptr;

    logic adv_rsp, adv_op;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gidx;
    logic               accept;
    logic [DATA_W-1:0]  sel_a, sel_b;
    logic [CTRL_W-1:0]  sel_ctrl;

    assign adv_rsp = !rsp_valid || rsp_ready;
    assign adv_op  = !op_valid || adv_rsp;

    // Gating with rst_n keeps req_ready low while reset is held.
    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .en     (adv_op && rst_n),
        .grant  (grant),
        .idx    (gidx),
        .any    (accept)
    );

    assign req_ready = grant;

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a    = req_a[i*DATA_W +: DATA_W];
                sel_b    = req_b[i*DATA_W +: DATA_W];
                sel_ctrl = req_ctrl[i*CTRL_W +: CTRL_W];
            end
        end
    end

    // Idle operand stage drives zeros so the shared ALU does not toggle.
    assign alu_a    = op_valid ? op_a    : '0;
    assign alu_b    = op_valid ? op_b    : '0;
    assign alu_ctrl = op_valid ? op_ctrl : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_valid  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_ctrl   <= '0;
            op_id     <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_id    <= '0;
        end else begin
            if (accept) begin
                op_valid <= 1'b1;
                op_a     <= sel_a;
                op_b     <= sel_b;
                op_ctrl  <= sel_ctrl;
                op_id    <= gidx;
                rr_ptr   <= (gidx == ID_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
            end else if (adv_op) begin
                op_valid <= 1'b0;
            end

            if (op_valid && adv_rsp) begin
                rsp_valid <= 1'b1;
                rsp_data  <= alu_out;
                rsp_zero  <= alu_zero;
                rsp_id    <= op_id;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule
